fft_butterfly_stage: RTL and testbench
======================================

Name: fft_butterfly_stage

Overview:
- Final radix-2 decimation-in-time combine stage of the audio FFT.
- Takes two half-length spectra (even-indexed and odd-indexed sub-FFTs) plus a packed twiddle table, and produces the full-length complex spectrum.
- Fixed-point arithmetic; twiddles are integers scaled by no_float_mult.
- Registered, fully pipelined: one new vector accepted per clock.

Parameters:
- twiddle_size, 16, bit width of each signed twiddle component.
- num_twiddles, 16, entries in the twiddle table; a power of two and >= buffer_size.
- buffer_size, 4, output FFT length N; a power of two, >= 2.
- sample_size, 32, bit width of each signed sample component.
- no_float_mult, 1000, twiddle scale factor; each twiddle product is divided by this value.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input vectors are valid this cycle.
- even_fft_real  in  N/2*sample_size  signed even-spectrum real parts; element k at [k*sample_size +: sample_size].
- even_fft_imag  in  N/2*sample_size  signed even-spectrum imaginary parts.
- odd_fft_real  in  N/2*sample_size  signed odd-spectrum real parts.
- odd_fft_imag  in  N/2*sample_size  signed odd-spectrum imaginary parts.
- twiddles_real  in  num_twiddles*twiddle_size  entry j = round(no_float_mult*cos(2*pi*j/num_twiddles)).
- twiddles_imag  in  num_twiddles*twiddle_size  entry j = round(-no_float_mult*sin(2*pi*j/num_twiddles)). Both tables are supplied by the twiddle storage block.
- out_valid  out  1  output vectors are valid.
- output_real  out  N*sample_size  signed result real parts; element m at [m*sample_size +: sample_size].
- output_imag  out  N*sample_size  signed result imaginary parts.

Behaviour:
- Per butterfly, for k = 0 .. N/2-1:
  - Twiddle index j = k*(num_twiddles/buffer_size); Wr, Wi = table entry j.
  - pr = (Wr*Or[k] - Wi*Oi[k]) / no_float_mult
  - pi = (Wr*Oi[k] + Wi*Or[k]) / no_float_mult
  - Products and sums are computed at full precision: sample_size + twiddle_size + 1 bits, signed.
  - Division is signed and truncates toward zero; it is applied once, after the sum.
  - out[k] = E[k] + (pr + j*pi)
  - out[k+N/2] = E[k] - (pr + j*pi)
  - Final sums are truncated (two's-complement wrap) to sample_size bits. There is no saturation.
- Pipeline, latency 2 cycles:
  - Stage 1 registers pr/pi, E and a valid bit on the edge where in_valid is sampled.
  - Stage 2 registers the add/subtract results into output_real/output_imag and out_valid.
- out_valid is high exactly 2 cycles after each in_valid=1 cycle.
- Back-to-back inputs produce back-to-back outputs. There is no stall or backpressure.
- When in_valid=0, the stage-1 valid bit is cleared, but data registers may still update. Downstream logic must qualify data with out_valid.
- Reset (rst_n=0, asynchronous):
  - All pipeline registers, output_real, output_imag and out_valid go to 0 immediately.
  - Reset mid-operation discards all in-flight vectors; no out_valid pulse follows for them.
  - The first input accepted after rst_n rises appears 2 cycles later.
- Twiddle inputs are treated as quasi-static. They are sampled in stage 1 together with the data.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> outputs and out_valid are 0 immediately and stay 0 until 2 cycles after the next in_valid.
- Directed default-parameter vector: E = {4+1j, 5+2j}, O = {2+5j, 3+6j}, standard table (W0=1000+0j, W4=0-1000j) -> out = {6+6j, 11-1j, 2-4j, -1+5j}, out_valid high 2 cycles after in_valid.
- Zero odd spectrum: O = 0, E = {7-3j, -2+9j} -> out = {7-3j, -2+9j, 7-3j, -2+9j}.
- Truncation toward zero: N=8, twiddle j=2 = 707-707j, O[1] = 1+0j, E = 0 -> pr = 0 (707/1000), pi = 0. With O[1] = -3+0j: pr = -2, pi = 2, so out[1] = -2+2j and out[5] = 2-2j.
- Throughput: drive 4 distinct vectors on consecutive cycles with in_valid=1 -> 4 consecutive out_valid cycles with matching, in-order results.
- Wrap: E[0] = 2^(sample_size-1)-1, O[0] = 1+0j, W0 = 1000 -> out[0] real wraps to -2^(sample_size-1); out[2] real = 2^(sample_size-1)-2.

Source files
------------

// File: rtl/fft_butterfly_stage.sv
// Final radix-2 DIT combine stage: twiddle-multiply the odd spectrum, then add/subtract
// against the even spectrum. Two-cycle registered pipeline, one vector per clock.
module fft_butterfly_stage #(
  parameter int twiddle_size  = 16,
  parameter int num_twiddles  = 16,
  parameter int buffer_size   = 4,
  parameter int sample_size   = 32,
  parameter int no_float_mult = 1000
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  input  logic [buffer_size/2*sample_size-1:0] even_fft_real,
  input  logic [buffer_size/2*sample_size-1:0] even_fft_imag,
  input  logic [buffer_size/2*sample_size-1:0] odd_fft_real,
  input  logic [buffer_size/2*sample_size-1:0] odd_fft_imag,
  input  logic [num_twiddles*twiddle_size-1:0] twiddles_real,
  input  logic [num_twiddles*twiddle_size-1:0] twiddles_imag,
  output logic                                 out_valid,
  output logic [buffer_size*sample_size-1:0]   output_real,
  output logic [buffer_size*sample_size-1:0]   output_imag
);

  localparam int half   = buffer_size / 2;
  localparam int hw     = half * sample_size;
  localparam int ow     = buffer_size * sample_size;
  localparam int stride = num_twiddles / buffer_size;
  localparam int pw     = sample_size + twiddle_size + 1;
  localparam logic signed [pw-1:0] scale = pw'(no_float_mult);

  logic signed [pw-1:0] o_r [half];
  logic signed [pw-1:0] o_i [half];
  logic signed [pw-1:0] w_r [half];
  logic signed [pw-1:0] w_i [half];

  logic [hw-1:0] pr_d, pi_d;
  logic [hw-1:0] pr_q, pi_q, er_q, ei_q;
  logic          v1;
  logic [ow-1:0] yr_d, yi_d;

  // Only every stride-th table entry is used at this FFT length.
  logic unused_tw;
  assign unused_tw = ^{twiddles_real, twiddles_imag};

  // Full-precision complex multiply; divide once after the sum (truncates toward zero).
  // Keeping only the low sample_size bits is exact since the final sums wrap anyway.
  always_comb begin
    pr_d = '0;
    pi_d = '0;
    for (int k = 0; k < half; k++) begin
      o_r[k] = pw'($signed(odd_fft_real[k*sample_size +: sample_size]));
      o_i[k] = pw'($signed(odd_fft_imag[k*sample_size +: sample_size]));
      w_r[k] = pw'($signed(twiddles_real[k*stride*twiddle_size +: twiddle_size]));
      w_i[k] = pw'($signed(twiddles_imag[k*stride*twiddle_size +: twiddle_size]));
      pr_d[k*sample_size +: sample_size] =
        sample_size'((w_r[k]*o_r[k] - w_i[k]*o_i[k]) / scale);
      pi_d[k*sample_size +: sample_size] =
        sample_size'((w_r[k]*o_i[k] + w_i[k]*o_r[k]) / scale);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      pr_q <= '0;
      pi_q <= '0;
      er_q <= '0;
      ei_q <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        pr_q <= pr_d;
        pi_q <= pi_d;
        er_q <= even_fft_real;
        ei_q <= even_fft_imag;
      end
    end
  end

  always_comb begin
    yr_d = '0;
    yi_d = '0;
    for (int k = 0; k < half; k++) begin
      yr_d[k*sample_size +: sample_size] =
        er_q[k*sample_size +: sample_size] + pr_q[k*sample_size +: sample_size];
      yi_d[k*sample_size +: sample_size] =
        ei_q[k*sample_size +: sample_size] + pi_q[k*sample_size +: sample_size];
      yr_d[(k+half)*sample_size +: sample_size] =
        er_q[k*sample_size +: sample_size] - pr_q[k*sample_size +: sample_size];
      yi_d[(k+half)*sample_size +: sample_size] =
        ei_q[k*sample_size +: sample_size] - pi_q[k*sample_size +: sample_size];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      output_real <= '0;
      output_imag <= '0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        output_real <= yr_d;
        output_imag <= yi_d;
      end
    end
  end

endmodule

// File: tb/tb_fft_butterfly_stage.sv
// Directed-vector bench for fft_butterfly_stage at N=4 and N=8 with the standard
// 16-entry twiddle table (scale 1000).
module tb_fft_butterfly_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         v4, v8, ov4, ov8;
  logic [63:0]  er4, ei4, or4, oi4;
  logic [127:0] er8, ei8, or8, oi8;
  logic [127:0] yr4, yi4;
  logic [255:0] yr8, yi8;
  logic [255:0] tr, ti;

  int tw_r [16] = '{1000, 924, 707, 383, 0, -383, -707, -924,
                    -1000, -924, -707, -383, 0, 383, 707, 924};
  int tw_i [16] = '{0, -383, -707, -924, -1000, -924, -707, -383,
                    0, 383, 707, 924, 1000, 924, 707, 383};

  int vectors = 0;
  int miscompares = 0;

  fft_butterfly_stage #(.twiddle_size(16), .num_twiddles(16), .buffer_size(4),
                        .sample_size(32), .no_float_mult(1000)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4),
    .even_fft_real(er4), .even_fft_imag(ei4),
    .odd_fft_real(or4), .odd_fft_imag(oi4),
    .twiddles_real(tr), .twiddles_imag(ti),
    .out_valid(ov4), .output_real(yr4), .output_imag(yi4)
  );

  fft_butterfly_stage #(.twiddle_size(16), .num_twiddles(16), .buffer_size(8),
                        .sample_size(32), .no_float_mult(1000)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8),
    .even_fft_real(er8), .even_fft_imag(ei8),
    .odd_fft_real(or8), .odd_fft_imag(oi8),
    .twiddles_real(tr), .twiddles_imag(ti),
    .out_valid(ov8), .output_real(yr8), .output_imag(yi8)
  );

  function automatic logic [63:0] p2(input int a, input int b);
    return {b, a};
  endfunction

  function automatic logic [127:0] p4(input int a, input int b, input int c, input int d);
    return {d, c, b, a};
  endfunction

  function automatic logic [255:0] p8(input int a, input int b, input int c, input int d,
                                      input int e, input int f, input int g, input int h);
    return {p4(e, f, g, h), p4(a, b, c, d)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic set4(input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] c, input logic [63:0] d);
    er4 = a; ei4 = b; or4 = c; oi4 = d;
  endtask

  initial begin
    v4 = 0; v8 = 0;
    set4('0, '0, '0, '0);
    er8 = '0; ei8 = '0; or8 = '0; oi8 = '0;
    for (int j = 0; j < 16; j++) begin
      tr[j*16 +: 16] = 16'(tw_r[j]);
      ti[j*16 +: 16] = 16'(tw_i[j]);
    end

    repeat (2) tick();
    chk("reset_valid", 256'(ov4), 256'(0));
    chk("reset_real", 256'(yr4), 256'(0));
    chk("reset_imag", 256'(yi4), 256'(0));
    rst_n = 1'b1;
    tick();

    // Default vector: E={4+1j,5+2j}, O={2+5j,3+6j}
    set4(p2(4, 5), p2(1, 2), p2(2, 3), p2(5, 6));
    v4 = 1; tick(); v4 = 0;
    chk("lat1_valid_low", 256'(ov4), 256'(0));
    tick();
    chk("dir_valid", 256'(ov4), 256'(1));
    chk("dir_real", 256'(yr4), 256'(p4(6, 11, 2, -1)));
    chk("dir_imag", 256'(yi4), 256'(p4(6, -1, -4, 5)));
    tick();
    chk("dir_valid_drop", 256'(ov4), 256'(0));

    // Zero odd spectrum
    set4(p2(7, -2), p2(-3, 9), '0, '0);
    v4 = 1; tick(); v4 = 0; tick();
    chk("zero_valid", 256'(ov4), 256'(1));
    chk("zero_real", 256'(yr4), 256'(p4(7, -2, 7, -2)));
    chk("zero_imag", 256'(yi4), 256'(p4(-3, 9, -3, 9)));

    // Two's-complement wrap
    set4(p2(2147483647, 0), '0, p2(1, 0), '0);
    v4 = 1; tick(); v4 = 0; tick();
    chk("wrap_real", 256'(yr4), 256'(p4(int'(32'h80000000), 0, 2147483646, 0)));
    chk("wrap_imag", 256'(yi4), 256'(0));

    // Throughput: four vectors back to back
    set4(p2(1, 0), '0, p2(10, 0), '0);
    v4 = 1; tick();
    set4('0, '0, '0, p2(0, 7));
    tick();
    chk("tp1_valid", 256'(ov4), 256'(1));
    chk("tp1_real", 256'(yr4), 256'(p4(11, 0, -9, 0)));
    chk("tp1_imag", 256'(yi4), 256'(0));
    set4(p2(2, 0), p2(2, 0), '0, '0);
    tick();
    chk("tp2_valid", 256'(ov4), 256'(1));
    chk("tp2_real", 256'(yr4), 256'(p4(0, 7, 0, -7)));
    chk("tp2_imag", 256'(yi4), 256'(0));
    set4('0, '0, p2(0, 5), '0);
    tick();
    chk("tp3_valid", 256'(ov4), 256'(1));
    chk("tp3_real", 256'(yr4), 256'(p4(2, 0, 2, 0)));
    chk("tp3_imag", 256'(yi4), 256'(p4(2, 0, 2, 0)));
    v4 = 0;
    tick();
    chk("tp4_valid", 256'(ov4), 256'(1));
    chk("tp4_real", 256'(yr4), 256'(0));
    chk("tp4_imag", 256'(yi4), 256'(p4(0, -5, 0, 5)));
    tick();
    chk("tp_end_valid", 256'(ov4), 256'(0));

    // Truncation toward zero at N=8 (twiddle j=2 = 707-707j)
    or8 = p4(0, 1, 0, 0);
    v8 = 1; tick(); v8 = 0; tick();
    chk("trunc1_valid", 256'(ov8), 256'(1));
    chk("trunc1_real", yr8, 256'(0));
    chk("trunc1_imag", yi8, 256'(0));
    or8 = p4(0, -3, 0, 0);
    v8 = 1; tick(); v8 = 0; tick();
    chk("trunc3_real", yr8, p8(0, -2, 0, 0, 0, 2, 0, 0));
    chk("trunc3_imag", yi8, p8(0, 2, 0, 0, 0, -2, 0, 0));

    // Reset mid-stream discards the in-flight vector
    set4(p2(4, 5), p2(1, 2), p2(2, 3), p2(5, 6));
    v4 = 1; tick(); v4 = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 256'(ov4), 256'(0));
    chk("rst_mid_real", 256'(yr4), 256'(0));
    chk("rst_mid_imag", 256'(yi4), 256'(0));
    rst_n = 1'b1;
    tick();
    chk("rst_flush1", 256'(ov4), 256'(0));
    tick();
    chk("rst_flush2", 256'(ov4), 256'(0));
    chk("rst_flush_real", 256'(yr4), 256'(0));

    // First vector after reset
    set4(p2(7, -2), p2(-3, 9), '0, '0);
    v4 = 1; tick(); v4 = 0;
    chk("post_rst_lat1", 256'(ov4), 256'(0));
    tick();
    chk("post_rst_valid", 256'(ov4), 256'(1));
    chk("post_rst_real", 256'(yr4), 256'(p4(7, -2, 7, -2)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
